// File: rtl/snd_rdsched_if.sv
`default_nettype none
// ============================================================================
// snd_rdsched_if : AXI read address/data channel bundle for the sound-IP
//                  read master (AR + R channels only).
// Revision 1.0
// ============================================================================
interface snd_rdsched_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rvalid, rlast
    );
endinterface
`default_nettype wire

// File: rtl/snd_rdsched.sv
`default_nettype none
// ============================================================================
// snd_rdsched : shares one AXI read master between NCH sample FIFOs; one INCR
//               burst at a time, beats steered to the granted FIFO.
// Optional macro: SND_RDSCHED_BGM_PRIO_EN (ch0 strict priority over ch1..)
// Revision 1.0
// ============================================================================
module snd_rdsched #(
    parameter int NCH        = 5,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 512
) (
    input  wire                   aclk,
    input  wire                   arst,
    input  wire                   rst,
    input  wire [NCH-1:0]         req,
    input  wire [NCH*32-1:0]      addr,
    input  wire [NCH*8-1:0]       len,
    input  wire [NCH*CNT_W-1:0]   wr_data_cnt,
    snd_rdsched_if.master         axi,
    output logic [31:0]           fifo_din,
    output logic [NCH-1:0]        fifo_wr,
    output logic [NCH-1:0]        done,
    output logic                  len_err
);

    localparam int               PTR_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(NCH - 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [7:0]       beat_cnt;
    logic             supp;
    logic             sup_now;
    logic [NCH-1:0]   grant_oh;
    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   cand;
    logic             pick_vld;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx;
    logic [31:0]      sel_addr;
    logic [7:0]       sel_len;

    // A burst only fits if the whole burst lands without overflowing the FIFO.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = req[i] &
                (({1'b0, wr_data_cnt[i*CNT_W +: CNT_W]} +
                  (CNT_W + 1)'(len[i*8 +: 8]) + (CNT_W + 1)'(1)) <= DEPTH_C);
        end
    end

    always_comb begin
        cand     = elig;
        pick_vld = 1'b0;
        pick     = '0;
        idx      = rr_ptr;
`ifdef SND_RDSCHED_BGM_PRIO_EN
        if (elig[0]) begin
            pick_vld = 1'b1;
        end
        cand[0] = 1'b0;
`endif
        for (int k = 0; k < NCH; k++) begin
            if (!pick_vld && cand[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
            idx = (idx == LAST_C) ? '0 : idx + PTR_W'(1);
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick == PTR_W'(i)) begin
                sel_addr = addr[i*32 +: 32];
                sel_len  = len[i*8 +: 8];
            end
        end
    end

    always_comb begin
        next_ptr = (grant == LAST_C) ? '0 : grant + PTR_W'(1);
`ifdef SND_RDSCHED_BGM_PRIO_EN
        if (grant == '0) begin
            next_ptr = rr_ptr;
        end
`endif
    end

    assign grant_oh = {{(NCH-1){1'b0}}, 1'b1} << grant;
    // Once soft reset is seen during a burst, the rest of that burst is discarded.
    assign sup_now  = supp | rst;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            supp        <= 1'b0;
            axi.araddr  <= '0;
            axi.arlen   <= '0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            fifo_din    <= '0;
            fifo_wr     <= '0;
            done        <= '0;
            len_err     <= 1'b0;
        end else begin
            fifo_wr <= '0;
            done    <= '0;
            if (rst) begin
                rr_ptr  <= '0;
                len_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (!rst && pick_vld) begin
                        grant       <= pick;
                        axi.araddr  <= sel_addr;
                        axi.arlen   <= sel_len;
                        axi.arvalid <= 1'b1;
                        beat_cnt    <= '0;
                        supp        <= 1'b0;
                        state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rst) begin
                        supp <= 1'b1;
                    end
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rst) begin
                        supp <= 1'b1;
                    end
                    if (axi.rvalid) begin
                        fifo_din <= axi.rdata;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (!sup_now) begin
                            fifo_wr <= grant_oh;
                        end
                        if (axi.rlast) begin
                            if (!sup_now) begin
                                done <= grant_oh;
                            end
                            if (!rst) begin
                                rr_ptr <= next_ptr;
                                if (beat_cnt != axi.arlen) begin
                                    len_err <= 1'b1;
                                end
                            end
                            axi.rready <= 1'b0;
                            supp       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
